// File: rtl/timer_cfg_pkg.sv
// Shared types and constants for the timer configuration sequencer.
package timer_cfg_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned MAX_REGS = 4;
    localparam int unsigned CFG_W    = MAX_REGS * DATA_W;

    localparam logic [ADDR_W-1:0] REG_STRIDE   = 32'd4;
    localparam logic [1:0]        RESP_OKAY    = 2'b00;
    localparam logic [2:0]        PROT_DEFAULT = 3'b000;
    localparam logic [3:0]        WSTRB_FULL   = 4'hF;

    localparam logic [1:0] ERR_TIMEOUT  = 2'd0;
    localparam logic [1:0] ERR_BRESP    = 2'd1;
    localparam logic [1:0] ERR_RRESP    = 2'd2;
    localparam logic [1:0] ERR_MISMATCH = 2'd3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        DONE    = 3'd5,
        ERR     = 3'd6
    } state_e;

    typedef logic [MAX_REGS-1:0][DATA_W-1:0] cfg_words_t;

    // Byte address of timer register idx.
    function automatic logic [ADDR_W-1:0] reg_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [1:0] idx);
        return base + ADDR_W'(idx) * REG_STRIDE;
    endfunction

endpackage

// File: rtl/timer_cfg_seq_if.sv
// AXI4-Lite bus between the sequencer (master) and the timer block (slave).
interface timer_cfg_seq_if;
    import timer_cfg_pkg::*;

    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/timer_cfg_timeout.sv
// Wait counter: cleared (loaded with zero) on state entry, counts while enabled,
// flags expiry on the last allowed wait cycle.
module timer_cfg_timeout #(
    parameter int unsigned C_LIMIT = 255
) (
    input  logic ACLK,
    input  logic ARESET,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    localparam int unsigned CW = (C_LIMIT > 1) ? $clog2(C_LIMIT) : 1;

    logic [CW-1:0] cnt_q;

    // Count wait cycles; clear has priority over enable.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired_c = en && (cnt_q == CW'(C_LIMIT - 1));

endmodule

// File: rtl/timer_cfg_seq.sv
// Programs up to four timer registers over AXI4-Lite, reading each one back
// to verify it before moving on; reports done or a coded abort.
module timer_cfg_seq
    import timer_cfg_pkg::*;
#(
    parameter logic [31:0] C_BASE_ADDR = 32'h0000_0000,
    parameter int unsigned C_NUM_REGS  = 4,
    parameter int unsigned C_TIMEOUT   = 255
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             start,
    input  logic [CFG_W-1:0] cfg_data,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [1:0]       err_idx,
    timer_cfg_seq_if.master  m_axi
);

    localparam logic [1:0] LAST_IDX = 2'(C_NUM_REGS - 1);

    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    cfg_words_t        cfg_q, cfg_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [1:0]        err_idx_q, err_idx_d;

    logic       aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic       tmo_en, tmo_clr, tmo_expired;
    logic       abort;
    logic [1:0] abort_code;
    logic [1:0] idx_inc;

    assign aw_hs   = awvalid_q && m_axi.awready;
    assign w_hs    = wvalid_q  && m_axi.wready;
    assign b_hs    = bready_q  && m_axi.bvalid;
    assign ar_hs   = arvalid_q && m_axi.arready;
    assign r_hs    = rready_q  && m_axi.rvalid;
    assign idx_inc = idx_q + 2'd1;

    // Wait states are exactly the busy states; any state change restarts the count.
    assign tmo_en  = (state_q inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA});
    assign tmo_clr = (state_d != state_q);

    timer_cfg_timeout #(
        .C_LIMIT (C_TIMEOUT)
    ) u_timeout (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .clr       (tmo_clr),
        .en        (tmo_en),
        .expired_c (tmo_expired)
    );

    // Next-state and next-output logic; every output is the image of a flop.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cfg_d      = cfg_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        araddr_d   = araddr_q;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
        err_code_d = err_code_q;
        err_idx_d  = err_idx_q;
        abort      = 1'b0;
        abort_code = ERR_TIMEOUT;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d    = WR_REQ;
                    cfg_d      = cfg_data;
                    idx_d      = 2'd0;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    awvalid_d  = 1'b1;
                    wvalid_d   = 1'b1;
                    awaddr_d   = reg_addr(C_BASE_ADDR, 2'd0);
                    wdata_d    = cfg_data[DATA_W-1:0];
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    err_code_d = 2'd0;
                    err_idx_d  = 2'd0;
                end
            end
            WR_REQ: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end else if (tmo_expired) begin
                    abort = 1'b1;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    bready_d = 1'b0;
                    if (m_axi.bresp != RESP_OKAY) begin
                        abort      = 1'b1;
                        abort_code = ERR_BRESP;
                    end else begin
                        state_d   = RD_REQ;
                        arvalid_d = 1'b1;
                        araddr_d  = reg_addr(C_BASE_ADDR, idx_q);
                    end
                end else if (tmo_expired) begin
                    abort = 1'b1;
                end
            end
            RD_REQ: begin
                if (ar_hs) begin
                    state_d   = RD_DATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end else if (tmo_expired) begin
                    abort = 1'b1;
                end
            end
            RD_DATA: begin
                if (r_hs) begin
                    rready_d = 1'b0;
                    if (m_axi.rresp != RESP_OKAY) begin
                        abort      = 1'b1;
                        abort_code = ERR_RRESP;
                    end else if (m_axi.rdata != cfg_q[idx_q]) begin
                        abort      = 1'b1;
                        abort_code = ERR_MISMATCH;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = WR_REQ;
                        idx_d     = idx_inc;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = reg_addr(C_BASE_ADDR, idx_inc);
                        wdata_d   = cfg_q[idx_inc];
                    end
                end else if (tmo_expired) begin
                    abort = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort drops every handshake signal and latches the cause.
        if (abort) begin
            state_d    = ERR;
            awvalid_d  = 1'b0;
            wvalid_d   = 1'b0;
            bready_d   = 1'b0;
            arvalid_d  = 1'b0;
            rready_d   = 1'b0;
            busy_d     = 1'b0;
            error_d    = 1'b1;
            err_code_d = abort_code;
            err_idx_d  = idx_q;
        end
    end

    // State and output registers.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cfg_q      <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            araddr_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= '0;
            err_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cfg_q      <= cfg_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            araddr_q   <= araddr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            err_idx_q  <= err_idx_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign err_code = err_code_q;
    assign err_idx  = err_idx_q;

    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awprot  = PROT_DEFAULT;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = WSTRB_FULL;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.araddr  = araddr_q;
    assign m_axi.arprot  = PROT_DEFAULT;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

endmodule
